// File: rtl/div_serial_pkg.sv
// Shared state encoding and handshake constants for the serial divider.
package div_serial_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResReady    = 1'b1;
    localparam logic DivResNotReady = 1'b0;
    localparam logic DivStart       = 1'b1;
    localparam logic DivStop        = 1'b0;

endpackage

// File: rtl/div_serial_if.sv
// EX-stage divide handshake: EX is the master, the divider is the slave.
interface div_serial_if #(
    parameter int unsigned DATA_W = 32
);
    logic                signed_div_i;
    logic [DATA_W-1:0]   opdata1_i;
    logic [DATA_W-1:0]   opdata2_i;
    logic                start_i;
    logic                annul_i;
    logic [2*DATA_W-1:0] result_o;
    logic                ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_serial.sv
// Multi-cycle radix-2 restoring divider returning {remainder, quotient}.
// One quotient bit per clock; signed operation works on magnitudes and fixes signs at the end.
module div_serial
    import div_serial_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    div_serial_if.slave  bus
);

    localparam int unsigned CNT_W  = $clog2(DATA_W) + 1;
    localparam int unsigned WORK_W = 2 * DATA_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic                op1_neg, op2_neg;
    logic [DATA_W-1:0]   op1_abs, op2_abs;
    logic [WORK_W-1:0]   shifted, step;
    logic [DATA_W:0]     upper, diff;
    logic [DATA_W-1:0]   quo_raw, rem_raw, quo_fin, rem_fin;

    assign op1_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    assign op2_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    assign op1_abs = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
    assign op2_abs = op2_neg ? -bus.opdata2_i : bus.opdata2_i;

    // Partial remainder lives in the upper DATA_W+1 bits, quotient fills in from bit 0.
    assign shifted = work_q << 1;
    assign upper   = shifted[WORK_W-1:DATA_W];
    assign diff    = upper - {1'b0, divisor_q};
    assign step    = (upper >= {1'b0, divisor_q}) ? {diff, shifted[DATA_W-1:1], 1'b1} : shifted;

    assign quo_raw = step[DATA_W-1:0];
    assign rem_raw = step[2*DATA_W-1:DATA_W];
    assign quo_fin = neg_quo_q ? -quo_raw : quo_raw;
    assign rem_fin = neg_rem_q ? -rem_raw : rem_raw;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            DivFree: begin
                if (bus.start_i == DivStart && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d   = DivOn;
                        cnt_d     = '0;
                        work_d    = {{(DATA_W + 1){1'b0}}, op1_abs};
                        divisor_d = op2_abs;
                        neg_quo_d = op1_neg ^ op2_neg;
                        neg_rem_d = op1_neg;
                    end
                end
            end
            DivByZero: begin
                state_d  = DivEnd;
                result_d = '0;
            end
            DivOn: begin
                if (bus.annul_i) begin
                    state_d = DivFree;
                    cnt_d   = '0;
                end else begin
                    work_d = step;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d  = DivEnd;
                        cnt_d    = '0;
                        result_d = {rem_fin, quo_fin};
                    end
                end
            end
            DivEnd: begin
                // annul is not looked at here: EX raises it only together with dropping start.
                if (bus.start_i == DivStop) begin
                    state_d  = DivFree;
                    ready_d  = DivResNotReady;
                    result_d = '0;
                end else begin
                    ready_d = DivResReady;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_serial.sv
// Directed bench for div_serial: transaction-level reference model plus literal expectations.
module tb_div_serial;

    localparam int unsigned W        = 32;
    localparam int          LAT_ON   = W + 1;
    localparam int          LAT_ZERO = 2;

    logic clk = 1'b0;
    logic rst;

    div_serial_if #(.DATA_W(W)) bus ();

    div_serial #(.DATA_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Plain-arithmetic reference: truncating division, remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = {32'h0, a};
            sb = {32'h0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Model: edges since start was accepted; ready is due LAT edges later while start is held.
    logic        m_busy = 1'b0;
    logic        m_zero = 1'b0;
    int          m_n    = 0;
    int          m_lat;
    logic [63:0] m_res  = 64'd0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (bus.start_i && !bus.annul_i) begin
                m_busy = 1'b1;
                m_n    = 0;
                m_zero = (bus.opdata2_i == 32'd0);
                m_res  = ref_div(bus.opdata1_i, bus.opdata2_i, bus.signed_div_i);
            end
        end else begin
            m_lat = m_zero ? LAT_ZERO : LAT_ON;
            if (m_n >= m_lat - 1 && !bus.start_i) m_busy = 1'b0;
            else if (!m_zero && m_n <= m_lat - 2 && bus.annul_i) m_busy = 1'b0;
            else if (m_n < m_lat) m_n++;
        end
    end

    logic chk_en = 1'b0;
    logic exp_ready;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_ready = m_busy && (m_n >= (m_zero ? LAT_ZERO : LAT_ON));
            check("ready", {63'b0, bus.ready_o}, {63'b0, exp_ready});
            if (exp_ready) check("result", bus.result_o, m_res);
            else if (!m_busy) check("result_idle", bus.result_o, 64'd0);
        end
    end

    // Present operands, let the next edge sample them, then scramble them to prove they're ignored.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        @(posedge clk); #1;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.signed_div_i = sgn;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b0;
        @(posedge clk); #1;
        bus.opdata1_i    = ~a;
        bus.opdata2_i    = 32'h3;
        bus.signed_div_i = ~sgn;
    endtask

    task automatic wait_ready(input string name, input int exp_lat);
        int e = 0;
        while (!bus.ready_o && e < 100) begin
            @(posedge clk); #1;
            e++;
        end
        check(name, 64'(e), 64'(exp_lat));
    endtask

    task automatic drop(input string name);
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        check(name, {63'b0, bus.ready_o}, 64'd0);
    endtask

    initial begin
        int seen;
        rst              = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {63'b0, bus.ready_o}, 64'd0);
        check("reset_result", bus.result_o, 64'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        check("model_100_7", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        check("model_m7_2", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        check("model_ovf", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'h0, 32'h8000_0000});

        launch(32'd100, 32'd7, 1'b0);
        wait_ready("lat_100_7", LAT_ON);
        check("res_100_7", bus.result_o, {32'd2, 32'd14});
        drop("drop_100_7");

        launch(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_ready("lat_m7_2", LAT_ON);
        check("res_m7_2", bus.result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        drop("drop_m7_2");

        launch(32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_ready("lat_7_m2", LAT_ON);
        check("res_7_m2", bus.result_o, {32'd1, 32'hFFFF_FFFD});
        drop("drop_7_m2");

        launch(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1);
        wait_ready("lat_m100_m7", LAT_ON);
        check("res_m100_m7", bus.result_o, {32'hFFFF_FFFE, 32'd14});
        drop("drop_m100_m7");

        launch(32'd5, 32'd0, 1'b0);
        wait_ready("lat_div0", LAT_ZERO);
        check("res_div0", bus.result_o, 64'd0);
        drop("drop_div0");

        // Annul sampled on the 10th ON edge, start dropped with it.
        launch(32'h1234, 32'd5, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        bus.annul_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.ready_o) seen = 1;
        end
        check("annul_no_ready", 64'(seen), 64'd0);

        launch(32'hFFFF_FFFF, 32'h10, 1'b0);
        wait_ready("lat_after_annul", LAT_ON);
        check("res_after_annul", bus.result_o, {32'hF, 32'h0FFF_FFFF});
        drop("drop_after_annul");

        launch(32'd12345678, 32'd3, 1'b1);
        repeat (19) @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready", {63'b0, bus.ready_o}, 64'd0);
        check("midrst_result", bus.result_o, 64'd0);
        rst = 1'b0;

        launch(32'd9, 32'd3, 1'b0);
        wait_ready("lat_after_rst", LAT_ON);
        check("res_after_rst", bus.result_o, {32'd0, 32'd3});
        drop("drop_after_rst");

        launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_ready("lat_ovf", LAT_ON);
        repeat (5) begin
            @(posedge clk); #1;
            check("hold_ready", {63'b0, bus.ready_o}, 64'd1);
            check("hold_result", bus.result_o, {32'h0, 32'h8000_0000});
        end
        drop("drop_ovf");

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
